// File: rtl/sweep_frequency_gen.sv
// Square-wave generator whose period is swept up or down by period>>shift on divided external ticks.
// Output toggles every (period+1) clks; tick actions land 3 clk edges after the tick is first sampled high; no backpressure.
module sweep_frequency_gen #(
    parameter int PERIOD_W   = 11,
    parameter int SHIFT_W    = 3,
    parameter int DIV_W      = 3,
    parameter int NEG_ONES   = 0,
    parameter int MIN_PERIOD = 8
) (
    input  logic                clk,
    input  logic                iReset_n,
    input  logic                iSweep_tick,
    input  logic                iSweep_enable,
    input  logic                iSweep_negate,
    input  logic [SHIFT_W-1:0]  iSweep_shift,
    input  logic [DIV_W-1:0]    iSweep_divider,
    input  logic                iSweep_reload,
    input  logic                iPeriod_load,
    input  logic [PERIOD_W-1:0] iPeriod,
    output logic                oData,
    output logic [PERIOD_W-1:0] oPeriod,
    output logic                oMute,
    output logic                oSweep_update
);

    localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W:0]   NEG_ADJ = (NEG_ONES != 0) ? {{PERIOD_W{1'b0}}, 1'b1} : '0;

    logic [PERIOD_W-1:0] curPeriod;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] delta;
    logic [PERIOD_W-1:0] target;
    logic [PERIOD_W:0]   sum;
    logic [PERIOD_W:0]   diff;
    logic                overflow;
    logic                tickS1, tickS2, tickS3;
    logic                tickRise;
    logic [DIV_W-1:0]    divCnt;
    logic                reloadFlag;
    logic                update;

    assign oPeriod = curPeriod;

    // Next sweep target; a negative decrement result clamps to zero.
    always_comb begin
        delta    = curPeriod >> iSweep_shift;
        sum      = {1'b0, curPeriod} + {1'b0, delta};
        diff     = {1'b0, curPeriod} - {1'b0, delta} - NEG_ADJ;
        overflow = sum[PERIOD_W];
        target   = sum[PERIOD_W-1:0];
        if (iSweep_negate) begin
            target = diff[PERIOD_W] ? '0 : diff[PERIOD_W-1:0];
        end
    end

    assign oMute    = (curPeriod < MIN_P) | (~iSweep_negate & overflow);
    assign tickRise = tickS2 & ~tickS3;
    assign update   = tickRise & (divCnt == '0) & iSweep_enable
                    & (iSweep_shift != '0) & ~oMute;

    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            tickS1 <= 1'b0;
            tickS2 <= 1'b0;
            tickS3 <= 1'b0;
        end else begin
            tickS1 <= iSweep_tick;
            tickS2 <= tickS1;
            tickS3 <= tickS2;
        end
    end

    // A period load overrides both the timer reload and any same-clk sweep write.
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            curPeriod <= '0;
            timer     <= '0;
            oData     <= 1'b0;
        end else begin
            if (timer == '0) begin
                oData <= oMute ? 1'b0 : ~oData;
            end
            if (iPeriod_load) begin
                curPeriod <= iPeriod;
                timer     <= iPeriod;
            end else begin
                if (update) begin
                    curPeriod <= target;
                end
                if (timer == '0) begin
                    timer <= curPeriod;
                end else begin
                    timer <= timer - 1'b1;
                end
            end
        end
    end

    // A reload request arriving with the tick itself applies to that tick.
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            divCnt     <= '0;
            reloadFlag <= 1'b0;
        end else if (tickRise) begin
            if ((divCnt == '0) || reloadFlag || iSweep_reload) begin
                divCnt     <= iSweep_divider;
                reloadFlag <= 1'b0;
            end else begin
                divCnt <= divCnt - 1'b1;
            end
        end else if (iSweep_reload) begin
            reloadFlag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            oSweep_update <= 1'b0;
        end else begin
            oSweep_update <= update & ~iPeriod_load;
        end
    end

endmodule

// File: doc/sweep_frequency_gen.md
Name: sweep_frequency_gen

Overview:
Parametrised successor square-wave frequency generator with hardware period sweep for the audio channel path. A programmable down-counter toggles oData every (period+1) clocks. A slow external sweep tick, divided by a programmable divider, shifts the period up or down by period>>shift. The block adds overflow/underflow detection, mute logic, selectable ones/twos-complement negate, and explicit period load and divider reload controls.

Parameters:
PERIOD_W, 11, width of period, timer and target arithmetic
SHIFT_W, 3, width of iSweep_shift
DIV_W, 3, width of sweep divider reload value
NEG_ONES, 0, 1 = negate subtracts an extra 1 (ones-complement channel); 0 = plain subtract
MIN_PERIOD, 8, periods below this value mute the output

Ports:
clk  in  1  system clock, all state on rising edge
iReset_n  in  1  asynchronous active-low reset
iSweep_tick  in  1  slow sweep clock, asynchronous to clk
iSweep_enable  in  1  allow sweep period updates
iSweep_negate  in  1  0 = period increases, 1 = period decreases
iSweep_shift  in  SHIFT_W  delta = cur_period >> iSweep_shift
iSweep_divider  in  DIV_W  sweep acts every (iSweep_divider+1) tick rises
iSweep_reload  in  1  one-clk pulse; divider reloads on the next tick rise
iPeriod_load  in  1  one-clk pulse; load iPeriod into period and timer
iPeriod  in  PERIOD_W  period value for load
oData  out  1  square output
oPeriod  out  PERIOD_W  current period register
oMute  out  1  combinational mute flag
oSweep_update  out  1  one-clk pulse when sweep wrote a new period

Behaviour:
- Reset (async, iReset_n=0): cur_period=0, timer=0, oData=0, div_cnt=0, reload_flag=0, sync flops=0, oSweep_update=0. oMute reads 1 because period 0 < MIN_PERIOD.
- Tick sync: 3-flop chain s1,s2,s3 on iSweep_tick. tick_rise = s2 & ~s3.
  - Tick-rise actions take effect on the 3rd clk edge after iSweep_tick is first sampled high.
- Timer, every clk:
  - If timer==0: timer <= cur_period; oData <= oMute ? 0 : ~oData.
  - Else: timer <= timer-1.
  - Output period is 2*(P+1) clks.
- Target, combinational, PERIOD_W+1 bits:
  - delta = cur_period >> iSweep_shift (logical shift, zero fill).
  - negate=0: target = cur_period + delta; overflow = carry out of bit PERIOD_W-1.
  - negate=1: target = cur_period - delta - NEG_ONES; result clamps to 0 if negative.
- oMute = (cur_period < MIN_PERIOD) | (~iSweep_negate & overflow).
- On tick_rise:
  - update = (div_cnt==0) & iSweep_enable & (iSweep_shift!=0) & ~oMute.
  - If update: cur_period <= target; oSweep_update=1 for one clk.
  - If div_cnt==0 or reload_flag: div_cnt <= iSweep_divider, reload_flag <= 0. Else div_cnt <= div_cnt-1.
  - The divider counts regardless of iSweep_enable.
- iSweep_reload sets reload_flag, which stays set until the next tick_rise. If iSweep_reload and tick_rise occur in the same clk, the flag applies to that tick.
- iPeriod_load: cur_period <= iPeriod, timer <= iPeriod.
  - Load has priority over a same-clk sweep update; that update is discarded and no oSweep_update pulse is issued.
  - Divider bookkeeping still proceeds.
- A sweep update does not reload the timer. The new period takes effect at the next timer expiry.
- When muted, the sweep is frozen: cur_period holds and oData is driven 0 at each timer expiry.
- iReset_n asserted mid-operation clears all state immediately, independent of clk.

Test Plan:
- Reset, then iPeriod=9 load -> oMute=0; oData toggles every 10 clks (20-clk period); oPeriod=9.
- Load iPeriod=5 -> oMute=1; oData goes 0 at the next expiry and stays 0.
- Period 0x100, shift=1, divider=0, negate=0, 6 tick rises -> oPeriod 0x180, 0x240, 0x360, 0x510, 0x798.
  - 6th tick: target 0xB64 overflows -> oMute=1, period holds 0x798, no oSweep_update.
- Period 0x100, shift=2, negate=1 -> NEG_ONES=1 gives 0xBF; NEG_ONES=0 gives 0xC0. Each update shows oSweep_update high for exactly 1 clk.
- divider=2 -> updates on tick rises 1, 4, 7.
  - iSweep_reload after tick 2 -> next update on tick 3 reloads without updating; the following update lands on tick 6.
  - iPeriod_load coincident with an update -> loaded value wins, no pulse.
- iReset_n low between clk edges mid-sweep -> oData=0, oPeriod=0, oSweep_update=0 immediately; oMute=1.
